// File: rtl/int_to_fp.sv
// Three-stage pipelined int32/uint32 to IEEE-754 single converter.
// Output is always a normalised float or +0.0, round-to-nearest-even or truncate.
module int_to_fp #(
  parameter bit SIGNED = 1'b1,
  parameter bit ROUND  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  input  logic [31:0] a0,
  output logic        out_valid,
  output logic [31:0] ret
);

  logic        w_sign0;
  logic [31:0] w_mag0;

  logic        r1_valid;
  logic        r1_sign;
  logic [31:0] r1_mag;
  logic [4:0]  w_nz1;
  logic        w_zero1;

  logic        r2_valid;
  logic        r2_sign;
  logic        r2_zero;
  logic [4:0]  r2_nz;
  logic [31:0] r2_mag;

  logic [31:0] w_sh;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rup;
  logic [24:0] w_sum;
  logic [7:0]  w_exp;

  // Two's-complement negate of 0x80000000 yields 0x80000000, which is 2^31 unsigned.
  assign w_sign0 = SIGNED & a0[31];
  assign w_mag0  = w_sign0 ? (~a0 + 32'd1) : a0;

  assign w_zero1 = (r1_mag == 32'd0);

  always_comb begin
    w_nz1 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r1_mag[i]) w_nz1 = 5'(31 - i);
    end
  end

  assign w_sh     = r2_mag << r2_nz;
  assign w_frac   = w_sh[30:8];
  assign w_guard  = w_sh[7];
  assign w_sticky = |w_sh[6:0];
  assign w_rup    = ROUND & w_guard & (w_sticky | w_frac[0]);
  // Carry out of the 24-bit mantissa renormalises to 1.0 * 2^(exp+1); frac bits are already 0.
  assign w_sum    = {2'b01, w_frac} + {24'd0, w_rup};
  assign w_exp    = 8'd158 - {3'd0, r2_nz} + {7'd0, w_sum[24]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_mag    <= 32'd0;
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_zero   <= 1'b0;
      r2_nz     <= 5'd0;
      r2_mag    <= 32'd0;
      out_valid <= 1'b0;
      ret       <= 32'd0;
    end else if (ce) begin
      r1_valid  <= in_valid;
      r1_sign   <= w_sign0;
      r1_mag    <= w_mag0;
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_zero   <= w_zero1;
      r2_nz     <= w_nz1;
      r2_mag    <= r1_mag;
      out_valid <= r2_valid;
      ret       <= r2_zero ? 32'd0 : {r2_sign, w_exp, w_sum[22:0]};
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Scoreboard bench for int_to_fp: three parameterisations driven in lockstep.
`timescale 1ns/1ps
module tb_int_to_fp;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a0 = 32'd0;
  logic [31:0] nx0 = 32'd0, nx1 = 32'd0, nx2 = 32'd0;

  logic        ov_ss, ov_nr, ov_us;
  logic [31:0] rt_ss, rt_nr, rt_us;

  int   n_chk = 0;
  int   n_pass = 0;
  int   ecount = 0;
  bit   last_adv = 1'b0;
  bit   last_rst = 1'b1;
  logic        prev_ov = 1'b0;
  logic [31:0] prev_rt = 32'd0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  int_to_fp #(.SIGNED(1'b1), .ROUND(1'b1)) u_ss (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a0(a0),
    .out_valid(ov_ss), .ret(rt_ss));
  int_to_fp #(.SIGNED(1'b1), .ROUND(1'b0)) u_nr (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a0(a0),
    .out_valid(ov_nr), .ret(rt_nr));
  int_to_fp #(.SIGNED(1'b0), .ROUND(1'b1)) u_us (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a0(a0),
    .out_valid(ov_us), .ret(rt_us));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
  endtask

  // Reference conversion by explicit remainder/half comparison on a 64-bit magnitude.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input bit sgn, input bit rnd);
    bit neg;
    longint unsigned m, q, rem, half;
    int e, drop;
    neg = sgn && a[31];
    m = neg ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    if (m == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      drop = e - 23;
      q = m >> drop;
      rem = m & ((64'd1 << drop) - 1);
      half = 64'd1 << (drop - 1);
      if (rnd && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == 64'h100_0000) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {neg, 8'(127 + e), q[22:0]};
  endfunction

  always @(posedge clk) begin
    last_rst <= rst;
    last_adv <= ce && !rst;
    if (rst) begin
      sb_q.delete();
    end else if (ce) begin
      ecount <= ecount + 1;
      if (in_valid) sb_q.push_back('{e0: nx0, e1: nx1, e2: nx2, due: ecount + 3});
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (last_rst) begin
      check("rst_valid", {29'd0, ov_us, ov_nr, ov_ss}, 32'd0);
      check("rst_ret", rt_ss | rt_nr | rt_us, 32'd0);
    end else if (!last_adv) begin
      check("stall_valid", {31'd0, ov_ss}, {31'd0, prev_ov});
      check("stall_ret", rt_ss, prev_rt);
    end else if (sb_q.size() != 0 && sb_q[0].due == ecount) begin
      x = sb_q.pop_front();
      check("valid", {29'd0, ov_us, ov_nr, ov_ss}, 32'd7);
      check("ret_ss", rt_ss, x.e0);
      check("ret_nr", rt_nr, x.e1);
      check("ret_us", rt_us, x.e2);
    end else begin
      check("spurious_valid", {29'd0, ov_us, ov_nr, ov_ss}, 32'd0);
    end
    prev_ov <= ov_ss;
    prev_rt <= rt_ss;
  end

  task automatic step(input bit v, input logic [31:0] a, input bit c, input bit r);
    in_valid = v;
    a0 = a;
    ce = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_tbl(input logic [31:0] a, input logic [31:0] x0, x1, x2);
    nx0 = x0; nx1 = x1; nx2 = x2;
    step(1'b1, a, 1'b1, 1'b0);
  endtask

  task automatic issue_model(input logic [31:0] a, input bit c);
    nx0 = fp_model(a, 1'b1, 1'b1);
    nx1 = fp_model(a, 1'b1, 1'b0);
    nx2 = fp_model(a, 1'b0, 1'b1);
    step(1'b1, a, c, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    idle(2);

    issue_tbl(32'd1,        32'h3F800000, 32'h3F800000, 32'h3F800000);
    issue_tbl(32'hFFFFFFFF, 32'hBF800000, 32'hBF800000, 32'h4F800000);
    issue_tbl(32'd0,        32'h00000000, 32'h00000000, 32'h00000000);
    issue_tbl(32'd2,        32'h40000000, 32'h40000000, 32'h40000000);
    issue_tbl(32'h7FFFFFFF, 32'h4F000000, 32'h4EFFFFFF, 32'h4F000000);
    issue_tbl(32'h80000000, 32'hCF000000, 32'hCF000000, 32'h4F000000);
    issue_tbl(32'd16777217, 32'h4B800000, 32'h4B800000, 32'h4B800000);
    issue_tbl(32'd16777219, 32'h4B800002, 32'h4B800001, 32'h4B800002);
    idle(5);

    issue_tbl(32'd3, 32'h40400000, 32'h40400000, 32'h40400000);
    issue_tbl(32'd5, 32'h40A00000, 32'h40A00000, 32'h40A00000);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd77, 1'b0, 1'b0);
    idle(6);

    issue_model(32'd100, 1'b1);
    issue_model(32'hFFFF_FF00, 1'b1);
    issue_model(32'd9, 1'b1);
    step(1'b1, 32'd11, 1'b1, 1'b1);
    check("rstq_empty", sb_q.size(), 32'd0);
    issue_tbl(32'd3, 32'h40400000, 32'h40400000, 32'h40400000);
    idle(5);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom();
      if (i % 4 == 1) a = a >> $urandom_range(31, 0);
      if (i % 4 == 2) a = -(a >> $urandom_range(31, 8));
      if ($urandom_range(3, 0) == 0) step(1'b0, a, $urandom_range(1, 0) == 1, 1'b0);
      else issue_model(a, $urandom_range(4, 0) != 0);
    end
    idle(8);

    check("drain_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_to_fp.md
Name: int_to_fp

Overview:
- Pipelined 32-bit integer to IEEE-754 single-precision converter.
- Sits directly upstream of the FP multiplier. That multiplier accepts only normalised operands, so this block must always emit a normalised float or exact +0.0.
- Rounds to nearest-even. Fixed 3-cycle latency.
- Valid and clock-enable sideband lets the issuing logic stall the whole pipe.

Parameters:
- SIGNED, 1: 1 = input is two's-complement int32; 0 = input is uint32.
- ROUND, 1: 1 = round-to-nearest-even; 0 = truncate (round toward zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0, every pipeline register (data and valid) holds.
- in_valid  in  1  a0 carries an operand this cycle; sampled only when ce=1.
- a0  in  32  integer operand.
- out_valid  out  1  ret carries a result.
- ret  out  32  float result {sign, exp[7:0], frac[22:0]}.

Behaviour:
- Reset: the synchronous rst clears all stage registers. out_valid=0, ret=32'h0. Any operand in flight is discarded; there is no partial output.
- rst has priority over ce.
- Pipeline: three register stages, all gated by ce. An operand sampled at edge N (in_valid=1, ce=1) appears on ret with out_valid=1 after edge N+2, i.e. through 3 register stages.
- Each cycle with ce=0 adds one cycle of latency.
- Throughput: one operand per cycle. No back-pressure beyond ce.
- Stage 1 (input register):
  - Latch a0 and in_valid.
  - sign = SIGNED & a0[31].
  - mag (32-bit unsigned) = sign ? (~a0 + 1) : a0. For a0=32'h80000000 signed, mag = 32'h80000000 (2^31), no overflow.
- Stage 2 (leading-zero count):
  - Register sign, mag, valid.
  - zero = (mag == 0).
  - nz = count of leading zeros of mag, range 0..31; don't-care when zero=1.
- Stage 3 (normalise, round, pack):
  - sh = mag << nz, so sh[31] = 1.
  - exp = 158 - nz, as 8 bits (127 + 31 - nz).
  - frac = sh[30:8]; guard g = sh[7]; sticky s = |sh[6:0].
  - Round-up condition: ROUND=1 and g and (s or frac[0]).
  - Round-up is a 24-bit increment of {1, frac}. Carry-out sets frac = 0 and exp = exp + 1. Maximum exp after carry is 159, so there is no overflow to Inf.
  - ROUND=0 never increments.
  - If zero: ret = 32'h0. Sign is forced 0 even when SIGNED, i.e. no -0.0.
  - Else ret = {sign, exp, frac}.
  - out_valid = stage-2 valid.
- Stage-3 data when valid=0: ret still updates from stage-2 data. Consumers must qualify ret with out_valid.
- Every result is exact or correctly rounded, and always normalised (exp in 127..159) or +0.0. Denormals, NaN and Inf are never produced.
- Simultaneous events:
  - in_valid=1 with ce=0: the operand is not accepted. The issuer must hold it.
  - rst=1 with in_valid=1: the operand is dropped.

Test Plan:
- SIGNED=1,ROUND=1; a0 = 1, -1, 0, 2, in consecutive cycles -> out_valid high for 4 consecutive cycles starting 3 cycles after the first; ret = 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000.
- Signed extremes: a0 = 32'h7FFFFFFF -> 32'h4F000000 (rounding carry bumps exp to 158); a0 = 32'h80000000 -> 32'hCF000000.
- Ties and rounding:
  - a0 = 16777217 (tie, even) -> 32'h4B800000.
  - a0 = 16777219 (tie, odd) -> 32'h4B800002.
  - With ROUND=0, a0 = 16777219 -> 32'h4B800001.
- SIGNED=0: a0 = 32'hFFFFFFFF -> 32'h4F800000; a0 = 32'h80000000 -> 32'h4F000000 (positive).
- Stall:
  - Issue A=3, then B=5.
  - Hold ce=0 for 2 cycles after B enters stage 1 -> out_valid and ret frozen during the stall.
  - Results 32'h40400000 then 32'h40A00000 arrive 2 cycles later than unstalled, in order, with no duplicates.
- Reset mid-flight:
  - Issue 3 operands; assert rst for 1 cycle while all 3 are in the pipe.
  - Required: out_valid=0 and ret=0 the cycle after reset; none of the 3 results ever appear; the next operand issued after reset emerges with normal 3-cycle latency.
